// File: rtl/button_debounce_top.sv
// button_debounce_top: debounces one mechanical push-button.
// It produces a clean level, a one-clock press pulse and an 8-bit press count.
// Optional build macro: BUTTON_ACTIVE_LOW_EN. When it is defined the button is
// treated as pressed when low, and the synchroniser flops reset to 1.
module button_debounce_top #(
    parameter int  DEBOUNCE_CYCLES = 50000,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b_in,
    output logic       b_out_level,
    output logic       b_out_pulse,
    output logic [7:0] leds
);

    // Terminal count: the level flips on the edge where the counter holds this value
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BUTTON_ACTIVE_LOW_EN
    // The flops carry the raw pin, so reset them to the pin's idle (released) level
    localparam logic SYNC_RST = 1'b1;
`else
    localparam logic SYNC_RST = 1'b0;
`endif

    logic             b_s1;
    logic             b_s2;
    logic             pressed;
    logic [CNT_W-1:0] cnt_reg;
    logic             level_reg;
    logic             pulse_reg;
    logic [7:0]       leds_reg;

    // Two-flop synchroniser; nothing else ever samples b_in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_s1 <= SYNC_RST;
            b_s2 <= SYNC_RST;
        end else begin
            b_s1 <= b_in;
            b_s2 <= b_s1;
        end
    end

`ifdef BUTTON_ACTIVE_LOW_EN
    assign pressed = ~b_s2;
`else
    assign pressed = b_s2;
`endif

    // Debounce counter, debounced level, press pulse and press counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            pulse_reg <= 1'b0;
            leds_reg  <= 8'h00;
        end else begin
            pulse_reg <= 1'b0;
            if (pressed == level_reg) begin
                // Any return to the current level restarts the qualification window
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                level_reg <= pressed;
                cnt_reg   <= '0;
                if (pressed) begin
                    // Pulse and count only on a press, never on a release
                    pulse_reg <= 1'b1;
                    leds_reg  <= leds_reg + 8'd1;
                end
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign b_out_level = level_reg;
    assign b_out_pulse = pulse_reg;
    assign leds        = leds_reg;

endmodule

// File: tb/tb_button_debounce_top.sv
// tb_button_debounce_top: random and directed button stimulus.
// A reference model predicts each debounced event and pushes it to a queue.
// A monitor pops each queued event when the DUT shows a level change or a pulse,
// and compares the two.
module tb_button_debounce_top;

    localparam int D = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b_in = 1'b0;
    logic       b_out_level;
    logic       b_out_pulse;
    logic [7:0] leds;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulse_seen = 0;

    typedef struct {
        int         cyc;
        bit         lvl;
        bit         pls;
        logic [7:0] leds;
    } ev_t;

    ev_t exp_q[$];

    button_debounce_top #(.DEBOUNCE_CYCLES(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .b_in        (b_in),
        .b_out_level (b_out_level),
        .b_out_pulse (b_out_pulse),
        .leds        (leds)
    );

    always #5 clk = ~clk;

    // Reference model. The level flips at edge n when the raw pin sampled at
    // edges n-D-1 .. n-2 (two synchroniser edges earlier) all disagree with
    // the current level. Samples taken while in reset are discarded.
    bit         hist[$];
    bit         m_lvl = 1'b0;
    logic [7:0] m_cnt = 8'h00;
    bit         all_flip;
    ev_t        m_ev;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                hist.delete();
                m_lvl = 1'b0;
                m_cnt = 8'h00;
            end else begin
                hist.push_back(b_in);
                if (hist.size() > D + 2) void'(hist.pop_front());
                all_flip = (hist.size() == D + 2);
                for (int k = 0; k < D; k++) begin
                    if (all_flip && hist[k] == m_lvl) all_flip = 1'b0;
                end
                if (all_flip) begin
                    m_lvl = ~m_lvl;
                    if (m_lvl) m_cnt = m_cnt + 8'd1;
                    m_ev.cyc  = cyc;
                    m_ev.lvl  = m_lvl;
                    m_ev.pls  = m_lvl;
                    m_ev.leds = m_cnt;
                    exp_q.push_back(m_ev);
                end
            end
        end
    end

    // Monitor: pops a predicted event whenever the DUT presents one
    initial begin
        bit  prev_lvl;
        ev_t e;
        prev_lvl = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                prev_lvl = 1'b0;
                continue;
            end
            if (b_out_level !== prev_lvl || b_out_pulse !== 1'b0) begin
                total++;
                if (b_out_pulse === 1'b1) pulse_seen++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event cyc=%0d got level=%b pulse=%b leds=%0d, required no event",
                             cyc, b_out_level, b_out_pulse, leds);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.lvl !== b_out_level || e.pls !== b_out_pulse || e.leds !== leds) begin
                        bad++;
                        $display("FAIL event got cyc=%0d level=%b pulse=%b leds=%0d, required cyc=%0d level=%b pulse=%b leds=%0d",
                                 cyc, b_out_level, b_out_pulse, leds, e.cyc, e.lvl, e.pls, e.leds);
                    end else begin
                        $display("event ok cyc=%0d level=%b pulse=%b leds=%0d", cyc, b_out_level, b_out_pulse, leds);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                total++;
                bad++;
                e = exp_q.pop_front();
                $display("FAIL missed_event at cyc=%0d got level=%b leds=%0d, required level=%b leds=%0d",
                         e.cyc, b_out_level, leds, e.lvl, e.leds);
            end
            prev_lvl = b_out_level;
        end
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end else begin
            $display("check ok %s = %0d", name, act);
        end
    endtask

    // Hold b_in at v for exactly n rising edges (changed on the falling edge)
    task automatic drive(input bit v, input int n);
        @(negedge clk);
        b_in = v;
        repeat (n - 1) @(negedge clk);
    endtask

    // Bursts shorter than D toward v, separated by one-clock returns
    task automatic bouncy(input bit v);
        int n;
        n = $urandom_range(3, 6);
        repeat (n) begin
            drive(v, $urandom_range(2, 4));
            drive(~v, 1);
        end
    endtask

    int start_pulses;

    initial begin
        repeat (5) @(negedge clk);
        check("reset_level", int'(b_out_level), 0);
        check("reset_pulse", int'(b_out_pulse), 0);
        check("reset_leds", int'(leds), 0);
        rst = 1'b0;

        drive(0, 4 * D);
        check("idle_level", int'(b_out_level), 0);
        check("idle_leds", int'(leds), 0);

        bouncy(1'b1);
        drive(1, 3 * D);
        check("press_level", int'(b_out_level), 1);
        check("press_leds", int'(leds), 1);

        bouncy(1'b0);
        drive(0, 2 * D);
        check("release_level", int'(b_out_level), 0);
        check("release_leds", int'(leds), 1);

        repeat (5) begin
            bouncy(1'b1);
            drive(1, 2 * D);
            bouncy(1'b0);
            drive(0, 2 * D);
        end
        check("five_presses_leds", int'(leds), 6);
        check("five_presses_level", int'(b_out_level), 0);

        drive(1, D - 1);
        drive(0, 2 * D);
        check("glitch_dm1_leds", int'(leds), 6);
        drive(1, D);
        drive(0, 2 * D);
        check("glitch_d_leds", int'(leds), 7);

        repeat (200) drive($urandom_range(0, 1), $urandom_range(1, 2 * D));
        drive(0, 3 * D);
        check("random_leds", int'(leds), int'(m_cnt));
        check("random_level", int'(b_out_level), 0);

        // Wrap: 256 clean presses from a fresh reset
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start_pulses = pulse_seen;
        repeat (256) begin
            drive(1, D + 3);
            drive(0, D + 3);
        end
        check("wrap_leds", int'(leds), 0);
        check("wrap_pulses", pulse_seen - start_pulses, 256);

        // Asynchronous reset while pressed and mid-count
        drive(1, 2 * D);
        check("pre_reset_leds", int'(leds), 1);
        drive(0, D / 2);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_level", int'(b_out_level), 0);
        check("async_pulse", int'(b_out_pulse), 0);
        check("async_leds", int'(leds), 0);
        b_in = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(1, 2 * D);
        check("held_through_reset_leds", int'(leds), 1);
        drive(0, 2 * D);
        check("end_level", int'(b_out_level), 0);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
